// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic P_CORE = 1'b0;
  localparam logic P_DBG  = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = 2;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin arbiter with registered pointer
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] win,
  output logic       ptr
);

  // Lone requester always wins; the pointer only breaks ties.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = (ptr == P_DBG) ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

  // After each arbitration the pointer moves to the losing port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= P_CORE;
    end else if (upd && (|win)) begin
      ptr <= ~win[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of a single-port data memory between two requesters
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $fatal(1, "dmem_arbiter: RD_LAT must be within 1..4");
  end

  state_t              state_q, state_d;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          win;
  logic                arb_ptr;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .upd   (state_q == IDLE),
    .win   (win),
    .ptr   (arb_ptr)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus per-state strobes; memory strobes exist only in ISSUE.
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|win) state_d = ISSUE;
      end
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        gnt0    = (owner_q == P_CORE);
        gnt1    = (owner_q == P_DBG);
        state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rvalid0 = (owner_q == P_CORE);
          rvalid1 = (owner_q == P_DBG);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the winning request and run the read-latency down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= P_CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && (|win)) begin
        owner_q <= win[1];
        we_q    <= win[1] ? we1    : we0;
        addr_q  <= win[1] ? addr1  : addr0;
        wdata_q <= win[1] ? wdata1 : wdata0;
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_W'(RD_LAT - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata0    = mem_rdata;
  assign rdata1    = mem_rdata;
  assign busy      = (state_q != IDLE);

endmodule
